// File: rtl/sample_mem_server.sv
// sample_mem_server: single-line read cache that serves 16-bit sample words
// from 64-bit DDRAM words.
// Ports:
//   CLK, RESET          - system clock, async active-high reset
//   s_addr, s_read      - sample byte address and one-cycle read strobe
//   s_data, s_ready     - returned sample word and one-cycle valid pulse
//   flush               - invalidates the line buffer
//   ddr_addr, ddr_rd    - DDRAM 64-bit word address and held read request
//   ddr_busy            - DDRAM cannot accept a request this cycle
//   ddr_dout, ddr_dout_ready - DDRAM read data and its valid strobe
module sample_mem_server #(
  parameter logic [28:0] BASE_ADDR = 29'h0300000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] s_addr,
  input  logic        s_read,
  output logic [15:0] s_data,
  output logic        s_ready,
  input  logic        flush,
  output logic [28:0] ddr_addr,
  output logic        ddr_rd,
  input  logic        ddr_busy,
  input  logic [63:0] ddr_dout,
  input  logic        ddr_dout_ready
);

  localparam int unsigned HW_W   = 23;  // halfword address s_addr[23:1]
  localparam int unsigned TAG_W  = 21;  // line tag s_addr[23:3]
  localparam int unsigned LINE_W = 64;
  localparam int unsigned DDR_W  = 29;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_data_q, line_data_d;
  logic [TAG_W-1:0]    line_tag_q, line_tag_d;
  logic                valid_q, valid_d;
  logic [HW_W-1:0]     addr_q, addr_d;
  logic                pend_valid_q, pend_valid_d;
  logic [HW_W-1:0]     pend_addr_q, pend_addr_d;
  logic                flushed_q, flushed_d;
  logic [15:0]         s_data_q, s_data_d;
  logic                s_ready_q, s_ready_d;
  logic                ddr_rd_q, ddr_rd_d;
  logic [DDR_W-1:0]    ddr_addr_q, ddr_addr_d;

  logic [HW_W-1:0]     req_addr;
  logic                hit;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = s_addr[0];

  // Select one 16-bit lane of a 64-bit word.
  function automatic logic [15:0] lane_sel(input logic [63:0] w, input logic [1:0] sel);
    logic [15:0] r;
    case (sel)
      2'd0:    r = w[15:0];
      2'd1:    r = w[31:16];
      2'd2:    r = w[47:32];
      default: r = w[63:48];
    endcase
    return r;
  endfunction

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    line_data_d  = line_data_q;
    line_tag_d   = line_tag_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    flushed_d    = flushed_q | flush;
    s_data_d     = s_data_q;
    s_ready_d    = 1'b0;
    ddr_rd_d     = ddr_rd_q;
    ddr_addr_d   = ddr_addr_q;
    req_addr     = s_addr[23:1];
    hit          = 1'b0;

    if (flush) valid_d = 1'b0;

    // Requests that cannot be serviced now are parked; a newer one replaces an older one.
    // IDLE also parks while s_ready is high so pulses can never be back to back.
    if (s_read && (state_q != IDLE || s_ready_q)) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = s_addr[23:1];
    end

    case (state_q)
      IDLE: begin
        if (!s_ready_q && (s_read || pend_valid_q)) begin
          req_addr     = s_read ? s_addr[23:1] : pend_addr_q;
          pend_valid_d = 1'b0;
          // A flush in the same cycle forces the miss path.
          hit = valid_q && !flush && (line_tag_q == req_addr[HW_W-1:2]);
          if (hit) begin
            s_data_d  = lane_sel(line_data_q, req_addr[1:0]);
            s_ready_d = 1'b1;
          end else begin
            addr_d     = req_addr;
            ddr_addr_d = BASE_ADDR + DDR_W'(req_addr[HW_W-1:2]);
            ddr_rd_d   = 1'b1;
            flushed_d  = flush;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!ddr_busy) begin
          ddr_rd_d = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (ddr_dout_ready) begin
          line_data_d = ddr_dout;
          line_tag_d  = addr_q[HW_W-1:2];
          valid_d     = !(flushed_q || flush);
          s_data_d    = lane_sel(ddr_dout, addr_q[1:0]);
          s_ready_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      flushed_q    <= 1'b0;
      s_data_q     <= '0;
      s_ready_q    <= 1'b0;
      ddr_rd_q     <= 1'b0;
      ddr_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_data_q  <= line_data_d;
      line_tag_q   <= line_tag_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      flushed_q    <= flushed_d;
      s_data_q     <= s_data_d;
      s_ready_q    <= s_ready_d;
      ddr_rd_q     <= ddr_rd_d;
      ddr_addr_q   <= ddr_addr_d;
    end
  end

  assign s_data   = s_data_q;
  assign s_ready  = s_ready_q;
  assign ddr_rd   = ddr_rd_q;
  assign ddr_addr = ddr_addr_q;

endmodule
